debug_reg_dumper: RTL and testbench

//  Downstream consumer of the single-cycle datapath's register-file debug port.
//  On a start pulse, steps debug_source_select through R0..R15 and captures debug_out for each.

---
 rtl/debug_reg_dumper_if.sv | 31 +++
 rtl/debug_reg_dumper.sv | 114 +++++++++++
 tb/tb_debug_reg_dumper.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_reg_dumper_if.sv
// Signal bundle between the register-file debug port, its dumper and the board UART pin.
// Handshake: start is a one-cycle request. It is honoured only when the dumper is idle.
// busy stays high from the accepted start until done, which is a single-cycle pulse.
interface debug_reg_dumper_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] debug_out;
    logic [3:0]       debug_source_select;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output debug_out,
        input  debug_source_select,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  debug_out,
        output debug_source_select,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/debug_reg_dumper.sv
// Sweeps the datapath debug port over R0..R(NUM_REGS-1) and sends each register
// as a 5-byte UART 8N1 frame: index byte, then the value MSB byte first.
module debug_reg_dumper #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16,
    parameter int CLK_DIV  = 868
) (
    input  logic                clk,
    input  logic                reset,
    debug_reg_dumper_if.slave   bus,
    output logic [2:0]          fsm_state
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_CAPTURE = 3'd2,
        S_SEND    = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       bit_idx;
    logic [2:0]       byte_cnt;
    logic [7:0]       cur_byte;

    assign fsm_state = state;

    always_comb begin
        cur_byte = 8'h00;
        case (byte_cnt)
            3'd0:    cur_byte = {4'h0, idx};
            3'd1:    cur_byte = shadow[31:24];
            3'd2:    cur_byte = shadow[23:16];
            3'd3:    cur_byte = shadow[15:8];
            3'd4:    cur_byte = shadow[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= S_IDLE;
            idx                     <= 4'd0;
            shadow                  <= '0;
            bit_cnt                 <= '0;
            bit_idx                 <= 4'd0;
            byte_cnt                <= 3'd0;
            bus.tx                  <= 1'b1;
            bus.busy                <= 1'b0;
            bus.done                <= 1'b0;
            bus.debug_source_select <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state                   <= S_SELECT;
                        bus.busy                <= 1'b1;
                        idx                     <= 4'd0;
                        bus.debug_source_select <= 4'd0;
                    end
                end
                S_SELECT: state <= S_CAPTURE;
                S_CAPTURE: begin
                    // tx drops here so the start bit lines up with the first SEND cycle
                    shadow   <= bus.debug_out;
                    byte_cnt <= 3'd0;
                    bit_cnt  <= '0;
                    bit_idx  <= 4'd0;
                    bus.tx   <= 1'b0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx <= 4'd0;
                            if (byte_cnt == 3'd4) begin
                                bus.tx <= 1'b1;
                                if (idx == IDX_LAST) begin
                                    state    <= S_FINISH;
                                    bus.busy <= 1'b0;
                                    bus.done <= 1'b1;
                                end else begin
                                    idx                     <= idx + 4'd1;
                                    bus.debug_source_select <= idx + 4'd1;
                                    state                   <= S_SELECT;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 3'd1;
                                bus.tx   <= 1'b0;
                            end
                        end else begin
                            // bit_idx 0..7 leads into data bit bit_idx; 8 leads into the stop bit
                            bit_idx <= bit_idx + 4'd1;
                            bus.tx  <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_reg_dumper.sv
// Bench for debug_reg_dumper: a register-file model feeds debug_out, a UART receiver
// decodes tx, and decoded bytes are scored against frames predicted at each start.
module tb_debug_reg_dumper;
    localparam int CLK_DIV   = 4;
    localparam int NREG      = 16;
    localparam int SWEEP_LEN = NREG * (2 + 50 * CLK_DIV) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  fsm_state;
    logic [31:0] regs [NREG];
    logic        corrupt;
    logic [7:0]  exp_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_count = 0;
    int cyc = 0;

    debug_reg_dumper_if #(.WIDTH(32)) dif ();

    debug_reg_dumper #(
        .WIDTH    (32),
        .NUM_REGS (NREG),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (dif.slave),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    always_comb dif.debug_out = corrupt ? 32'hDEADBEEF : regs[dif.debug_source_select];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep emits, per register, its index then the value MSB first.
    task automatic push_expected();
        for (int n = 0; n < NREG; n++) begin
            logic [31:0] v;
            v = regs[n];
            exp_q.push_back(8'(n));
            exp_q.push_back(v[31:24]);
            exp_q.push_back(v[23:16]);
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[7:0]);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 dif.start = 1'b1;
        @(posedge clk); #1 dif.start = 1'b0;
    endtask

    task automatic start_after_done();
        @(posedge clk); #1 dif.start = 1'b1;
        @(posedge clk); #1 dif.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < SWEEP_LEN + 200; i++) begin
            @(negedge clk);
            if (dif.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_select(input logic [3:0] want);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < SWEEP_LEN + 200; i++) begin
            @(posedge clk); #1;
            if (dif.debug_source_select == want && dif.busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("select_timeout", 32'(seen), 32'd1);
    endtask

    task automatic randomize_regs();
        for (int n = 0; n < NREG; n++) regs[n] = $urandom;
    endtask

    // Monitor: UART receiver plus sweep timing, all sampled on the falling edge.
    initial begin
        bit         rx_on;
        int         rx_cnt;
        int         bi;
        logic [7:0] rx_byte;
        logic [7:0] exp_b;
        logic       prev_tx, prev_busy, prev_done;
        int         first_busy;
        bit         tx_seen;
        int         sweep_bytes;
        rx_on = 1'b0; rx_cnt = 0; rx_byte = 8'h00;
        prev_tx = 1'b1; prev_busy = 1'b0; prev_done = 1'b0;
        first_busy = 0; tx_seen = 1'b1; sweep_bytes = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                rx_on = 1'b0; prev_tx = 1'b1; prev_busy = 1'b0; prev_done = 1'b0; tx_seen = 1'b1;
                continue;
            end
            if (dif.busy && !prev_busy) begin
                first_busy  = cyc;
                sweep_bytes = 0;
                tx_seen     = 1'b0;
            end
            if (!tx_seen && dif.tx == 1'b0) begin
                check("start_bit_latency", 32'(cyc - first_busy), 32'd2);
                tx_seen = 1'b1;
            end
            if (dif.done) begin
                done_count++;
                check("done_width", 32'(prev_done), 32'd0);
                check("busy_at_done", 32'(dif.busy), 32'd0);
                check("done_cycle", 32'(cyc - first_busy + 1), 32'(SWEEP_LEN));
                check("bytes_per_sweep", 32'(sweep_bytes), 32'd80);
            end
            if (!rx_on) begin
                if (prev_tx && !dif.tx) begin
                    rx_on  = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if ((rx_cnt - 1) % CLK_DIV == 0) begin
                    bi = (rx_cnt - 1) / CLK_DIV;
                    if (bi == 0) begin
                        check("start_bit_level", 32'(dif.tx), 32'd0);
                    end else if (bi <= 8) begin
                        rx_byte[bi-1] = dif.tx;
                    end else begin
                        check("stop_bit_level", 32'(dif.tx), 32'd1);
                        sweep_bytes++;
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_byte: got 0x%0h expected none at t=%0t", rx_byte, $time);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("frame_byte", 32'(rx_byte), 32'(exp_b));
                        end
                        rx_on = 1'b0;
                    end
                end
            end
            prev_tx   = dif.tx;
            prev_busy = dif.busy;
            prev_done = dif.done;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        dif.start = 1'b0;
        corrupt   = 1'b0;
        for (int n = 0; n < NREG; n++) regs[n] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(dif.tx), 32'd1);
        check("reset_busy", 32'(dif.busy), 32'd0);
        check("reset_done", 32'(dif.done), 32'd0);
        check("reset_select", 32'(dif.debug_source_select), 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-cycle while start is held
        #2 dif.start = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_tx", 32'(dif.tx), 32'd1);
        check("async_busy", 32'(dif.busy), 32'd0);
        check("async_done", 32'(dif.done), 32'd0);
        check("async_select", 32'(dif.debug_source_select), 32'd0);
        dif.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_reset_busy", 32'(dif.busy), 32'd0);
        check("idle_after_reset_tx", 32'(dif.tx), 32'd1);

        // Sweep A: fixed pattern, start re-pulses while busy, debug_out changed after R3 capture
        regs[0] = 32'h12345678;
        for (int n = 1; n < NREG; n++) regs[n] = 32'hA5A5_0000 + 32'(n);
        push_expected();
        pulse_start();
        fork
            begin
                repeat (8) @(posedge clk);
                #1 dif.start = 1'b1;
                @(posedge clk); #1 dif.start = 1'b0;
                repeat (1488) @(posedge clk);
                #1 dif.start = 1'b1;
                @(posedge clk); #1 dif.start = 1'b0;
            end
            begin
                wait_select(4'd3);
                repeat (2) @(posedge clk);
                #1 corrupt = 1'b1;
                wait_select(4'd4);
                corrupt = 1'b0;
            end
            wait_done();
        join

        // Sweeps B and C: random contents, each started in the idle cycle right after done
        randomize_regs();
        push_expected();
        start_after_done();
        wait_done();
        randomize_regs();
        push_expected();
        start_after_done();
        wait_done();

        // Sweep D: random contents, aborted by reset during byte 2 of R5
        randomize_regs();
        push_expected();
        repeat (3) @(posedge clk);
        pulse_start();
        wait_select(4'd5);
        repeat (2 + 2 * 10 * CLK_DIV + 5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midframe_reset_tx", 32'(dif.tx), 32'd1);
        check("midframe_reset_busy", 32'(dif.busy), 32'd0);
        check("midframe_reset_select", 32'(dif.debug_source_select), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("tx_high_in_reset", 32'(dif.tx), 32'd1);
        end
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("tx_idle_after_release", 32'(dif.tx), 32'd1);

        // Sweep E: fresh sweep after the abort
        randomize_regs();
        push_expected();
        pulse_start();
        wait_done();

        repeat (50) @(posedge clk);
        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        check("done_pulses", 32'(done_count), 32'd4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
